hdmi_frame_playout: RTL and testbench



---
 rtl/hdmi_frame_playout.sv | 158 +++++++++++++++
 tb/tb_hdmi_frame_playout.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hdmi_frame_playout.sv
// hdmi_frame_playout: streams a frame from a burst DMA through a pixel FIFO onto a registered video timing output.
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   playout_on                playout enable, sampled at each frame start
//   frm_addr_reset            one-cycle DMA read pointer restart at an enabled frame start
//   frm_burst_valid/_ready    burst request handshake, frm_burst = words - 1
//   frm_data_valid/_ready     DMA data beats, frm_data[23:0] = RGB, frm_data_last ends the burst
//   vid_vsync/hsync/de/rgb    registered video output
//   frame_height_width        constant {V_ACTIVE, H_ACTIVE} in 16-bit fields
//   underflow                 sticky flag: active pixel needed while the FIFO was empty
module hdmi_frame_playout #(
    parameter int H_SYNC     = 40,
    parameter int H_BP       = 220,
    parameter int H_ACTIVE   = 1280,
    parameter int H_FP       = 110,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 20,
    parameter int V_ACTIVE   = 720,
    parameter int V_FP       = 5,
    parameter int FIFO_DEPTH = 512,
    parameter int BURST_LEN  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        playout_on,
    output logic        frm_addr_reset,
    output logic        frm_burst_valid,
    input  logic        frm_burst_ready,
    output logic [7:0]  frm_burst,
    input  logic        frm_data_valid,
    output logic        frm_data_ready,
    input  logic [31:0] frm_data,
    input  logic        frm_data_last,
    output logic        vid_vsync,
    output logic        vid_hsync,
    output logic        vid_de,
    output logic [23:0] vid_rgb,
    output logic [31:0] frame_height_width,
    output logic        underflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] HT  = 16'(H_SYNC + H_BP + H_ACTIVE + H_FP);
    localparam logic [15:0] HS  = 16'(H_SYNC);
    localparam logic [15:0] HA0 = 16'(H_SYNC + H_BP);
    localparam logic [15:0] HA1 = 16'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [15:0] VT  = 16'(V_SYNC + V_BP + V_ACTIVE + V_FP);
    localparam logic [15:0] VS  = 16'(V_SYNC);
    localparam logic [15:0] VA0 = 16'(V_SYNC + V_BP);
    localparam logic [15:0] VA1 = 16'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [31:0] TOTAL = 32'(H_ACTIVE * V_ACTIVE);
    localparam logic [31:0] BL = 32'(BURST_LEN);
    // A new burst is only requested when a whole BURST_LEN fits, so the FIFO never overflows.
    localparam logic [AW:0] CNT_MAX = (AW+1)'(FIFO_DEPTH - BURST_LEN);

    logic [15:0]   h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic          frame_en_q, frame_en_d;
    logic [31:0]   remaining_q, remaining_d;
    logic          burst_valid_q, burst_valid_d;
    logic [7:0]    burst_q, burst_d;
    logic          outstanding_q, outstanding_d, drain_q, drain_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          underflow_q, underflow_d;
    logic [23:0]   mem [FIFO_DEPTH];
    logic          fs, h_end, handshake, beat, last, de_next, push, pop;
    logic [31:0]   n;
    logic          unused_hi;

    assign unused_hi = ^frm_data[31:24];

    always_comb begin
        fs         = (h_cnt_q == '0) && (v_cnt_q == '0);
        h_end      = h_cnt_q == HT - 16'd1;
        handshake  = burst_valid_q && frm_burst_ready;
        beat       = frm_data_valid && frm_data_ready;
        last       = beat && frm_data_last;
        de_next    = (h_cnt_q >= HA0) && (h_cnt_q < HA1) && (v_cnt_q >= VA0) && (v_cnt_q < VA1);
        // Beats landing on a frame start belong to the previous frame and are dropped.
        push       = beat && outstanding_q && !fs;
        pop        = de_next && frame_en_q && (count_q != '0);
        n          = (remaining_q < BL) ? remaining_q : BL;
        h_cnt_d    = h_end ? '0 : h_cnt_q + 16'd1;
        v_cnt_d    = !h_end ? v_cnt_q : (v_cnt_q == VT - 16'd1) ? '0 : v_cnt_q + 16'd1;
        frame_en_d = fs ? playout_on : frame_en_q;
        remaining_d = fs ? (playout_on ? TOTAL : '0) : handshake ? remaining_q - n : remaining_q;
        // A pending request is withdrawn at frame start; the new frame re-requests from the restarted pointer.
        burst_valid_d = !fs && !handshake && (burst_valid_q || (frame_en_q && (remaining_q != '0)
                        && !outstanding_q && !drain_q && (count_q <= CNT_MAX)));
        burst_d       = burst_valid_q ? burst_q : 8'(n - 32'd1);
        outstanding_d = !fs && (handshake || (outstanding_q && !last));
        // Any burst still in flight at frame start is swallowed up to its last beat.
        drain_d     = (drain_q && !last) || (fs && ((outstanding_q && !last) || handshake));
        wr_ptr_d    = fs ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d    = fs ? '0 : rd_ptr_q + AW'(pop);
        count_d     = fs ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
        hsync_d     = h_cnt_q < HS;
        vsync_d     = v_cnt_q < VS;
        de_d        = de_next;
        rgb_d       = pop ? mem[rd_ptr_q] : '0;
        underflow_d = underflow_q || (de_next && frame_en_q && (count_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_en_q    <= 1'b0;
            remaining_q   <= '0;
            burst_valid_q <= 1'b0;
            burst_q       <= '0;
            outstanding_q <= 1'b0;
            drain_q       <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            underflow_q   <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_en_q    <= frame_en_d;
            remaining_q   <= remaining_d;
            burst_valid_q <= burst_valid_d;
            burst_q       <= burst_d;
            outstanding_q <= outstanding_d;
            drain_q       <= drain_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            rgb_q         <= rgb_d;
            underflow_q   <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= frm_data[23:0];
    end

    // Outputs are forced low for the whole reset cycle, before the registers clear.
    assign frm_addr_reset     = !rst && fs && playout_on;
    assign frm_burst_valid    = !rst && burst_valid_q;
    assign frm_burst          = rst ? '0 : burst_q;
    assign frm_data_ready     = !rst && (outstanding_q || drain_q);
    assign vid_hsync          = !rst && hsync_q;
    assign vid_vsync          = !rst && vsync_q;
    assign vid_de             = !rst && de_q;
    assign vid_rgb            = rst ? '0 : rgb_q;
    assign underflow          = !rst && underflow_q;
    assign frame_height_width = {4'b0, 12'(V_ACTIVE), 4'b0, 12'(H_ACTIVE)};
endmodule

// File: tb/tb_hdmi_frame_playout.sv
// tb_hdmi_frame_playout: directed scoreboard bench for hdmi_frame_playout (main instance plus a partial-burst instance).
module tb_hdmi_frame_playout;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1, playout_on = 1'b0;

    logic a_ar, a_bv, a_br, a_dv, a_dr, a_dl, a_vs, a_hs, a_de, a_uf;
    logic [7:0] a_burst;
    logic [31:0] a_d, a_fhw;
    logic [23:0] a_rgb;
    logic b_ar, b_bv, b_dv, b_dr, b_dl, b_vs, b_hs, b_de, b_uf;
    logic b_br = 1'b1;
    logic [7:0] b_burst;
    logic [31:0] b_d, b_fhw;
    logic [23:0] b_rgb;

    hdmi_frame_playout #(.H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2), .V_SYNC(1), .V_BP(1),
        .V_ACTIVE(4), .V_FP(1), .FIFO_DEPTH(16), .BURST_LEN(4)) dut (
        .clk(clk), .rst(rst), .playout_on(playout_on), .frm_addr_reset(a_ar),
        .frm_burst_valid(a_bv), .frm_burst_ready(a_br), .frm_burst(a_burst),
        .frm_data_valid(a_dv), .frm_data_ready(a_dr), .frm_data(a_d), .frm_data_last(a_dl),
        .vid_vsync(a_vs), .vid_hsync(a_hs), .vid_de(a_de), .vid_rgb(a_rgb),
        .frame_height_width(a_fhw), .underflow(a_uf));

    hdmi_frame_playout #(.H_SYNC(2), .H_BP(2), .H_ACTIVE(6), .H_FP(2), .V_SYNC(1), .V_BP(1),
        .V_ACTIVE(3), .V_FP(1), .FIFO_DEPTH(16), .BURST_LEN(4)) dut_p (
        .clk(clk), .rst(rst), .playout_on(playout_on), .frm_addr_reset(b_ar),
        .frm_burst_valid(b_bv), .frm_burst_ready(b_br), .frm_burst(b_burst),
        .frm_data_valid(b_dv), .frm_data_ready(b_dr), .frm_data(b_d), .frm_data_last(b_dl),
        .vid_vsync(b_vs), .vid_hsync(b_hs), .vid_de(b_de), .vid_rgb(b_rgb),
        .frame_height_width(b_fhw), .underflow(b_uf));

    int checks = 0, errors = 0, cur = 0;
    logic [23:0] exp_q[$];
    logic [7:0] blog[$], blog_b[$];
    int addr = 0, baddr = 0, left = 0, wt = 0, late = 0, nbeat = 0, ar_cnt = 0, hs_cnt = 0;
    bit busy = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input int c);
        while (cur < c) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic push_frame(input bit live);
        for (int i = 0; i < 32; i++) exp_q.push_back(live ? 24'(i) : 24'd0);
    endtask

    task automatic chk_bursts(input string tag, input int nexp);
        chk({tag, "_count"}, blog.size(), nexp);
        foreach (blog[i]) chk({tag, "_len"}, blog[i], 8'd3);
        blog.delete();
    endtask

    // Video scoreboard: every active pixel pops one expectation; idle pixels must be black.
    initial forever begin
        @(negedge clk);
        if (!rst && a_de) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("rgb_active", a_rgb, exp_q.pop_front());
        end else if (!rst) chk("rgb_idle", a_rgb, 0);
    end

    // DMA model for the main instance; data word = frame-relative address with junk in [31:24].
    initial begin
        logic s_ar, s_hs, s_bt, s_rs;
        logic [7:0] s_bl;
        a_dv = 1'b0; a_d = '0; a_dl = 1'b0;
        forever begin
            @(negedge clk);
            s_ar = a_ar; s_hs = a_bv && a_br; s_bt = a_dv && a_dr; s_bl = a_burst; s_rs = rst;
            @(posedge clk);
            #1;
            if (s_rs) begin
                busy = 0; addr = 0; left = 0;
            end else begin
                if (s_bt) begin baddr++; left--; nbeat++; if (left == 0) busy = 0; end
                if (s_ar) begin addr = 0; ar_cnt++; end
                if (s_hs) begin
                    busy = 1; left = int'(s_bl) + 1; baddr = addr; addr += left;
                    wt = late; late = 0; nbeat = 0; hs_cnt++; blog.push_back(s_bl);
                end
            end
            a_dv = busy && wt == 0; a_d = {8'hA5, baddr[23:0]}; a_dl = left == 1;
            if (wt > 0) wt--;
        end
    end

    // Always-ready DMA model for the partial-burst instance.
    initial begin
        logic s_hs, s_bt, s_rs;
        logic [7:0] s_bl;
        int bleft = 0;
        b_dv = 1'b0; b_d = '0; b_dl = 1'b0;
        forever begin
            @(negedge clk);
            s_hs = b_bv && b_br; s_bt = b_dv && b_dr; s_bl = b_burst; s_rs = rst;
            @(posedge clk);
            #1;
            if (s_rs) bleft = 0;
            else begin
                if (s_bt) bleft--;
                if (s_hs) begin bleft = int'(s_bl) + 1; blog_b.push_back(s_bl); end
            end
            b_dv = bleft > 0; b_dl = bleft == 1; b_d = 32'(bleft);
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_b [5];
        exp_b = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd1};
        playout_on = 1'b1; a_br = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ar", a_ar, 0); chk("rst_bv", a_bv, 0); chk("rst_dr", a_dr, 0);
        chk("rst_de", a_de, 0); chk("rst_uf", a_uf, 0);
        chk("fhw_a", a_fhw, 32'h0004_0008); chk("fhw_b", b_fhw, 32'h0003_0006);
        push_frame(1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); cur = 0;
        // Frame A: normal playout.
        chk("a_first_ar", a_ar, 1); chk("a_bv_fs", a_bv, 0);
        go(2); chk("a_hsync_on", a_hs, 1); chk("a_vsync_on", a_vs, 1);
        chk("a_bv_rise", a_bv, 1); chk("a_burst_len", a_burst, 3);
        go(3); chk("a_hsync_off", a_hs, 0);
        go(14); chk("a_vsync_hold", a_vs, 1);
        go(15); chk("a_vsync_off", a_vs, 0);
        go(27); chk("b_gated_by_space", blog_b.size(), 4);
        go(32); chk("a_de_before", a_de, 0);
        go(33); chk("a_de_first", a_de, 1);
        go(41); chk("a_de_after", a_de, 0);
        go(71);
        chk("b_burst_count", blog_b.size(), 5);
        for (int i = 0; i < 5 && i < blog_b.size(); i++) chk("b_burst_seq", blog_b[i], exp_b[i]);
        chk("b_no_extra_req", b_bv, 0); chk("b_uf", b_uf, 0);
        go(97);
        chk("a_sb_drained", exp_q.size(), 0); chk("a_ar_once", ar_cnt, 1); chk("a_uf_clear", a_uf, 0);
        chk_bursts("a_bursts", 8);
        ar_cnt = 0; hs_cnt = 0;
        // Frame B: DMA stalled for the whole active area.
        a_br = 1'b0; push_frame(0);
        go(190);
        chk("b_frame_uf", a_uf, 1); chk("b_frame_sb", exp_q.size(), 0); chk("b_frame_hs", hs_cnt, 0);
        chk("b_frame_ar", ar_cnt, 1); chk("b_bv_hold", a_bv, 1); chk("b_burst_hold", a_burst, 3);
        // Release with a delayed response so the burst straddles the next frame start.
        late = 5; a_br = 1'b1; push_frame(1);
        go(198); chk("c_drain_ready", a_dr, 1); chk("c_drain_no_req", a_bv, 0);
        go(246); playout_on = 1'b0;
        go(293);
        chk("c_sb_drained", exp_q.size(), 0); chk("c_ar", ar_cnt, 2); chk("c_uf_sticky", a_uf, 1);
        chk_bursts("c_bursts", 9);
        ar_cnt = 0; hs_cnt = 0;
        // Frame D: playout disabled.
        push_frame(0);
        go(391);
        chk("d_sb_drained", exp_q.size(), 0); chk("d_no_ar", ar_cnt, 0); chk("d_no_req", hs_cnt, 0);
        chk("d_uf_sticky", a_uf, 1);
        blog.delete();
        playout_on = 1'b1;
        // Frame E: reset after two beats of the first burst.
        go(392);
        for (int i = 0; i < 40 && !(hs_cnt == 1 && nbeat == 2); i++) begin
            @(posedge clk); #2;
        end
        chk("e_two_beats", nbeat, 2);
        rst = 1'b1; ar_cnt = 0; hs_cnt = 0; blog.delete(); push_frame(1);
        @(negedge clk);
        chk("rst_mid_ar", a_ar, 0); chk("rst_mid_bv", a_bv, 0); chk("rst_mid_burst", a_burst, 0);
        chk("rst_mid_dr", a_dr, 0); chk("rst_mid_vs", a_vs, 0); chk("rst_mid_hs", a_hs, 0);
        chk("rst_mid_de", a_de, 0); chk("rst_mid_rgb", a_rgb, 0); chk("rst_mid_uf", a_uf, 0);
        chk("rst_mid_fhw", a_fhw, 32'h0004_0008);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); cur = 0;
        chk("f_ar", a_ar, 1); chk("f_dr", a_dr, 0); chk("f_uf", a_uf, 0);
        go(97);
        chk("f_sb_drained", exp_q.size(), 0); chk("f_ar_once", ar_cnt, 1); chk("f_uf_clear", a_uf, 0);
        chk_bursts("f_bursts", 8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
